// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Types and constants shared by the instruction-fetch sequencer.
//   EXC_*          : fetch exception codes carried by each delivered entry
//   fetch_state_e  : sequencer state (RUN issues reads, HALT waits for redirect)
//   fetch_entry_t  : one FIFO entry {instr, pc, exc_code}
//   make_entry()   : builds an entry from an IM response, applying the
//                    exception rules (a misalign tag outranks the IM range flag)
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam logic [1:0] EXC_NONE     = 2'd0;
   localparam logic [1:0] EXC_IMRANGE  = 2'd1;
   localparam logic [1:0] EXC_MISALIGN = 2'd2;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [1:0]  exc_code;
   } fetch_entry_t;

   // A misaligned fetch never looks at IM data, so its tag wins over im_exp.
   function automatic fetch_entry_t make_entry(input logic [31:0] instr,
                                               input logic [31:0] pc,
                                               input logic        misalign,
                                               input logic        im_exp);
      fetch_entry_t e;
      e.pc = pc;
      if (misalign) begin
         e.instr    = 32'h0000_0000;
         e.exc_code = EXC_MISALIGN;
      end else if (im_exp) begin
         e.instr    = 32'h0000_0000;
         e.exc_code = EXC_IMRANGE;
      end else begin
         e.instr    = instr;
         e.exc_code = EXC_NONE;
      end
      return e;
   endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl_if
// Bundles the fetch sequencer's buses:
//   IM read port : im_addr (out), im_instr / im_exp (in, one cycle after issue)
//   redirect     : redirect_valid / redirect_pc (in)
//   decode side  : out_valid / out_instr / out_pc / out_exc / out_exc_code (out),
//                  out_ready (in)
// master = the fetch sequencer, slave = its environment (IM + decode + redirect).
// -----------------------------------------------------------------------------
interface if_fetch_ctrl_if;

   logic [31:0] im_addr;
   logic [31:0] im_instr;
   logic        im_exp;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_exc;
   logic [1:0]  out_exc_code;

   modport master (
      output im_addr,
      input  im_instr,
      input  im_exp,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output out_exc,
      output out_exc_code
   );

   modport slave (
      input  im_addr,
      output im_instr,
      output im_exp,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  out_exc,
      input  out_exc_code
   );

endinterface

// File: rtl/fetch_skid_fifo.sv
// -----------------------------------------------------------------------------
// fetch_skid_fifo
// Two-entry FIFO implemented as a head register plus one tail register, so the
// head (what decode sees) is always a flop output.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   push_i/din_i : write an entry
//   pop_i        : drop the head (caller guarantees count_o != 0)
//   flush_i      : discard everything (wins over push/pop)
//   count_o      : occupancy 0..2
//   head_o       : oldest entry
// -----------------------------------------------------------------------------
module fetch_skid_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t din_i,
   output logic [1:0]   count_o,
   output fetch_entry_t head_o
);

   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   fetch_entry_t head_q, head_d;
   fetch_entry_t tail_q, tail_d;
   logic [1:0]   count_q, count_d;

   // Next-state for head/tail/count from push, pop and flush.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_d  = din_i;
                  count_d = 2'd1;
               end else if (count_q < FULL_CNT) begin
                  tail_d  = din_i;
                  count_d = count_q + 2'd1;
               end else begin
                  // Overflow: entry dropped, reported by the checker.
                  count_d = count_q;
               end
            end
            2'b01: begin
               if (count_q != 2'd0) begin
                  head_d  = tail_q;
                  tail_d  = '0;
                  count_d = count_q - 2'd1;
               end else begin
                  count_d = 2'd0;
               end
            end
            2'b11: begin
               if (count_q == FULL_CNT) begin
                  head_d = tail_q;
                  tail_d = din_i;
               end else begin
                  // Occupancy 1 (or 0): new entry becomes the head, count stays 1.
                  head_d  = din_i;
                  count_d = 2'd1;
               end
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end
   end

   // FIFO storage and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = head_q;

   fetch_skid_fifo_chk #(.DEPTH(DEPTH)) u_chk (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_i),
      .pop_i   (pop_i),
      .flush_i (flush_i),
      .count_i (count_q)
   );

endmodule

// File: rtl/fetch_skid_fifo_chk.sv
// -----------------------------------------------------------------------------
// fetch_skid_fifo_chk
// Simulation-only watchdog for the skid FIFO: a push that is neither matched
// by a pop nor discarded by a flush must never meet a full FIFO.
// Ports: clk, rst_n, push_i, pop_i, flush_i, count_i (current occupancy).
// -----------------------------------------------------------------------------
module fetch_skid_fifo_chk #(
   parameter int unsigned DEPTH = 2
) (
   input logic       clk,
   input logic       rst_n,
   input logic       push_i,
   input logic       pop_i,
   input logic       flush_i,
   input logic [1:0] count_i
);

   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !pop_i && !flush_i && (count_i == FULL_CNT)))
      else $error("fetch_skid_fifo overflow: push into full FIFO");

endmodule

// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
// Fetch sequencer in front of a 4 KB synchronous instruction memory whose read
// port returns data one cycle after the address is presented.  Owns the fetch
// PC, tracks the single in-flight read, buffers responses in a 2-entry skid
// FIFO and hands instructions to decode over valid/ready.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus (master)  : IM read port, redirect request, decode handshake
//   perf_fetched  : instructions delivered to decode
//   perf_bubbles  : cycles decode was ready but nothing was valid
// Optional feature: define IF_FETCH_PERF_EN to build the two performance
// counters; otherwise both outputs are tied to zero.
// -----------------------------------------------------------------------------
module if_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   if_fetch_ctrl_if.master      bus,
   output logic [31:0]          perf_fetched,
   output logic [31:0]          perf_bubbles
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         inflight_q, inflight_d;
   logic [31:0]  infl_pc_q, infl_pc_d;
   logic         infl_mis_q, infl_mis_d;

   logic [1:0]   count_s;
   fetch_entry_t head_s;
   fetch_entry_t push_entry_s;
   logic         valid_s;
   logic         pop_s;
   logic         push_s;
   logic         exc_push_s;
   logic         issue_s;
   logic [2:0]   occ_s;

   assign valid_s = (count_s != 2'd0);
   assign pop_s   = valid_s && bus.out_ready;

   // A response lands in the cycle after issue; a redirect in that cycle kills it.
   assign push_s       = inflight_q && !bus.redirect_valid;
   assign push_entry_s = make_entry(bus.im_instr, infl_pc_q, infl_mis_q, bus.im_exp);
   assign exc_push_s   = push_s && (push_entry_s.exc_code != EXC_NONE);

   // Entries buffered plus the one in flight, after this cycle's pop.  Capping
   // this at 1 before issuing guarantees the response always has room.
   assign occ_s = {1'b0, count_s} + {2'b00, inflight_q} - {2'b00, pop_s};

   // An exception push freezes the PC, so an issue in that cycle is suppressed
   // rather than made and later discarded.
   assign issue_s = (state_q == RUN) && !bus.redirect_valid && !exc_push_s
                    && (occ_s <= 3'd1);

   // Next PC, in-flight tracking and state; redirect has top priority.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inflight_d = 1'b0;
      infl_pc_d  = infl_pc_q;
      infl_mis_d = infl_mis_q;
      if (bus.redirect_valid) begin
         pc_d    = bus.redirect_pc;
         state_d = RUN;
      end else if (exc_push_s) begin
         state_d = HALT;
      end else if (issue_s) begin
         inflight_d = 1'b1;
         infl_pc_d  = pc_q;
         infl_mis_d = (pc_q[1:0] != 2'b00);
         pc_d       = pc_q + 32'd4;
      end else begin
         state_d = state_q;
      end
   end

   // Sequencer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
         infl_pc_q  <= 32'h0000_0000;
         infl_mis_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         infl_pc_q  <= infl_pc_d;
         infl_mis_q <= infl_mis_d;
      end
   end

   fetch_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .flush_i (bus.redirect_valid),
      .din_i   (push_entry_s),
      .count_o (count_s),
      .head_o  (head_s)
   );

   assign bus.im_addr      = pc_q;
   assign bus.out_valid    = valid_s;
   assign bus.out_instr    = head_s.instr;
   assign bus.out_pc       = head_s.pc;
   assign bus.out_exc_code = head_s.exc_code;
   assign bus.out_exc      = (head_s.exc_code != EXC_NONE);

`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_bubbles_q;

   // Delivered-instruction and decode-starvation counters; redirects leave them alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_q <= 32'h0000_0000;
         perf_bubbles_q <= 32'h0000_0000;
      end else begin
         if (pop_s) begin
            perf_fetched_q <= perf_fetched_q + 32'd1;
         end else begin
            perf_fetched_q <= perf_fetched_q;
         end
         if (bus.out_ready && !valid_s) begin
            perf_bubbles_q <= perf_bubbles_q + 32'd1;
         end else begin
            perf_bubbles_q <= perf_bubbles_q;
         end
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_bubbles = perf_bubbles_q;
`else
   assign perf_fetched = 32'h0000_0000;
   assign perf_bubbles = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_ctrl
// Directed bench for if_fetch_ctrl.  Inputs change and outputs are sampled on
// the falling edge; the IM model registers on the rising edge like the real
// 1024-word memory and flags addresses >= 0x1000.  IM word k holds A500_0000+k.
// -----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] perf_fetched;
   logic [31:0] perf_bubbles;
   logic [31:0] mem [0:1023];
   int          n_checks = 0;
   int          n_pass   = 0;

   if_fetch_ctrl_if bus ();

   if_fetch_ctrl #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .perf_fetched (perf_fetched),
      .perf_bubbles (perf_bubbles)
   );

   always #5 clk = ~clk;

   // Synchronous IM read port: registers every clock, cannot stall.
   always @(posedge clk) begin
      bus.im_instr <= mem[bus.im_addr[11:2]];
      bus.im_exp   <= (bus.im_addr >= 32'h0000_1000);
   end

   function automatic logic [31:0] word(input int k);
      return 32'hA500_0000 + 32'(k);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic expect_entry(input string tag, input logic [31:0] pc,
                               input logic [31:0] instr, input logic [1:0] code);
      check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".pc"},    bus.out_pc, pc);
      check({tag, ".instr"}, bus.out_instr, instr);
      check({tag, ".exc"},   32'(bus.out_exc), 32'(code != 2'd0));
      check({tag, ".code"},  32'(bus.out_exc_code), 32'(code));
   endtask

   task automatic expect_empty(input string tag);
      check({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected done by 100000");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 1024; k++) mem[k] = word(k);
      bus.im_instr       = 32'h0;
      bus.im_exp         = 1'b0;
      rst_n              = 1'b0;
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      cyc();
      cyc();

      // Reset state
      check("rst.valid", 32'(bus.out_valid), 32'd0);
      check("rst.pc", bus.out_pc, 32'h0);
      check("rst.instr", bus.out_instr, 32'h0);
      check("rst.exc", 32'(bus.out_exc), 32'd0);
      check("rst.code", 32'(bus.out_exc_code), 32'd0);
      check("rst.im_addr", bus.im_addr, 32'h0);
      check("rst.perf_f", perf_fetched, 32'h0);
      check("rst.perf_b", perf_bubbles, 32'h0);

      // Release: first issue at the next edge, out_valid two cycles later
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      cyc();
      expect_empty("start1");
      check("start1.im_addr", bus.im_addr, 32'h4);
      for (int k = 0; k < 10; k++) begin
         cyc();
         expect_entry($sformatf("stream%0d", k), 32'(4 * k), word(k), 2'd0);
      end

      // Backpressure for 5 cycles: head held, issue stops at PC 0x2C
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         expect_entry($sformatf("hold%0d", i), 32'h24, word(9), 2'd0);
         check($sformatf("hold%0d.im_addr", i), bus.im_addr, 32'h2C);
      end
      bus.out_ready = 1'b1;
      for (int k = 10; k < 15; k++) begin
         cyc();
         expect_entry($sformatf("resume%0d", k), 32'(4 * k), word(k), 2'd0);
      end

      // Redirect to 0x100 with an entry buffered and a read in flight
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h100;
      cyc();
      bus.redirect_valid = 1'b0;
      expect_empty("rd1.t1");
      check("rd1.im_addr", bus.im_addr, 32'h100);
      cyc();
      expect_empty("rd1.t2");
      cyc();
      expect_entry("rd1.t3", 32'h100, word(64), 2'd0);
      cyc();
      expect_entry("rd1.t4", 32'h104, word(65), 2'd0);

      // Redirect to the last IM word, then run off the end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFC;
      cyc();
      bus.redirect_valid = 1'b0;
      expect_empty("rng.t1");
      cyc();
      expect_empty("rng.t2");
      cyc();
      expect_entry("rng.last", 32'hFFC, word(1023), 2'd0);
      cyc();
      expect_entry("rng.exc", 32'h1000, 32'h0, 2'd1);
      cyc();
      expect_empty("rng.halt1");
      cyc();
      expect_empty("rng.halt2");
      check("rng.im_addr", bus.im_addr, 32'h1004);

      // Misaligned redirect target
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h102;
      cyc();
      bus.redirect_valid = 1'b0;
      expect_empty("mis.t1");
      cyc();
      expect_empty("mis.t2");
      cyc();
      expect_entry("mis.exc", 32'h102, 32'h0, 2'd2);
      cyc();
      expect_empty("mis.halt1");
      cyc();
      expect_empty("mis.halt2");
      check("mis.im_addr", bus.im_addr, 32'h106);

      // Redirect out of HALT resumes fetch at 0
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      cyc();
      bus.redirect_valid = 1'b0;
      cyc();
      cyc();
      expect_entry("resume0", 32'h0, word(0), 2'd0);
      cyc();
      expect_entry("resume1", 32'h4, word(1), 2'd0);

      // Reset mid-operation takes effect immediately
      rst_n = 1'b0;
      #1;
      check("mrst.valid", 32'(bus.out_valid), 32'd0);
      check("mrst.pc", bus.out_pc, 32'h0);
      check("mrst.im_addr", bus.im_addr, 32'h0);
      cyc();

      // Perf scenario: 8 pops, bubbles in the two start-up cycles plus one after a redirect
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      cyc();
      cyc();
      expect_entry("perf.first", 32'h0, word(0), 2'd0);
      for (int i = 0; i < 8; i++) cyc();
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h200;
      cyc();
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      cyc();
`ifdef IF_FETCH_PERF_EN
      check("perf.fetched", perf_fetched, 32'd8);
      check("perf.bubbles", perf_bubbles, 32'd3);
`else
      check("perf.fetched", perf_fetched, 32'd0);
      check("perf.bubbles", perf_bubbles, 32'd0);
`endif
      cyc();
      expect_entry("perf.redirect", 32'h200, word(128), 2'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
